clean_seq_monitor_passthru: RTL and testbench

// Trojan-free (golden) successor to the single-channel clean pass-through core. Generalises
// to NUM_CH slave data channels with a registered PIPE_STAGES-deep delay and valid tracking.

---
 rtl/clean_seq_monitor_passthru.sv | 175 +++++++++++++++++
 tb/tb_clean_seq_monitor_passthru.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clean_seq_monitor_passthru.sv
// ============================================================================
// Module  : clean_seq_monitor_passthru
// Purpose : Multi-channel registered pass-through with a read-only monitor
//           that flags a fixed trigger-word sequence on the master bus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module clean_seq_monitor_passthru #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int PIPE_STAGES = 1,
  parameter int SEQ_LEN     = 4,
  parameter logic [SEQ_LEN*DATA_WIDTH-1:0] TRIGGER_SEQ =
    {32'h0AAA5C5C, 32'hEAAAD8FF, 32'h354A7B6C, 32'h00000000},
  parameter int CNT_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m0_valid,
  input  logic [DATA_WIDTH-1:0]        m0_data_o,
  input  logic [NUM_CH-1:0]            i_s_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_s_data_o,
  input  logic                         cnt_clear,
  output logic [NUM_CH-1:0]            i_s_valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] i_s_data_o_TrojanPayload,
  output logic [1:0]                   seq_state,
  output logic                         seq_hit,
  output logic [CNT_WIDTH-1:0]         seq_hit_count
);

  localparam int BUS_W = NUM_CH * DATA_WIDTH;
  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_HIT   = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Pass-through delay line: loads every cycle, valid travels alongside data
  // --------------------------------------------------------------------------
  logic [BUS_W-1:0]  pipe_data_q  [PIPE_STAGES];
  logic [BUS_W-1:0]  pipe_data_d  [PIPE_STAGES];
  logic [NUM_CH-1:0] pipe_valid_q [PIPE_STAGES];
  logic [NUM_CH-1:0] pipe_valid_d [PIPE_STAGES];

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      always_comb begin
        pipe_data_d[s]  = i_s_data_o;
        pipe_valid_d[s] = i_s_valid;
      end
    end else begin : g_rest
      always_comb begin
        pipe_data_d[s]  = pipe_data_q[s-1];
        pipe_valid_d[s] = pipe_valid_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pipe_data_q[s]  <= '0;
        pipe_valid_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pipe_data_q[s]  <= pipe_data_d[s];
        pipe_valid_q[s] <= pipe_valid_d[s];
      end
    end
  end

  assign i_s_data_o_TrojanPayload = pipe_data_q[PIPE_STAGES-1];
  assign i_s_valid_o              = pipe_valid_q[PIPE_STAGES-1];

  // --------------------------------------------------------------------------
  // Sequence monitor (observes m0 only, never touches the data path)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] seq_word [SEQ_LEN];

  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_seq_word
    assign seq_word[k] = TRIGGER_SEQ[k*DATA_WIDTH +: DATA_WIDTH];
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 seq_hit_q, seq_hit_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 hit_entry;
  logic                 word_is_first;

  assign word_is_first = (m0_data_o == seq_word[0]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (m0_valid) begin
      case (state_q)
        // HIT restarts exactly like IDLE using the word presented this cycle
        ST_IDLE, ST_HIT: begin
          if (word_is_first) begin
            state_d = ST_MATCH;
            idx_d   = IDX_ONE;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
        ST_MATCH: begin
          if (m0_data_o == seq_word[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_HIT;
              idx_d   = '0;
            end else begin
              idx_d   = idx_q + IDX_ONE;
            end
          end else if (word_is_first) begin
            state_d = ST_MATCH;
            idx_d   = IDX_ONE;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end else if (state_q != ST_IDLE && state_q != ST_MATCH) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end
  end

  // HIT is only reachable from MATCH, so any transition into it is an entry
  assign hit_entry = (state_d == ST_HIT);

  always_comb begin
    seq_hit_d = hit_entry;
    count_d   = count_q;
    if (cnt_clear) begin
      count_d = '0;
    end else if (hit_entry && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      seq_hit_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_hit_q <= seq_hit_d;
      count_q   <= count_d;
    end
  end

  assign seq_state     = state_q;
  assign seq_hit       = seq_hit_q;
  assign seq_hit_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_clean_seq_monitor_passthru.sv
// Self-checking bench: scoreboard queue for the pass-through, explicit
// expectations for the sequence monitor.
`default_nettype none

module tb_clean_seq_monitor_passthru;

  localparam int DW   = 32;
  localparam int NCH  = 2;
  localparam int PIPE = 1;
  localparam int CNTW = 2;
  localparam int SBW  = NCH + NCH*DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_valid;
  logic [DW-1:0]   m0_data_o;
  logic [NCH-1:0]  i_s_valid;
  logic [NCH*DW-1:0] i_s_data_o;
  logic            cnt_clear;
  logic [NCH-1:0]  i_s_valid_o;
  logic [NCH*DW-1:0] i_s_data_o_TrojanPayload;
  logic [1:0]      seq_state;
  logic            seq_hit;
  logic [CNTW-1:0] seq_hit_count;

  int checks = 0;
  int errors = 0;

  logic [SBW-1:0] sb [$];
  logic [SBW-1:0] exp_pipe;
  logic [DW-1:0]  seqw [4];

  clean_seq_monitor_passthru #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .PIPE_STAGES(PIPE),
    .SEQ_LEN    (4),
    .TRIGGER_SEQ({32'h0AAA5C5C, 32'hEAAAD8FF, 32'h354A7B6C, 32'h00000000}),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .m0_valid                (m0_valid),
    .m0_data_o               (m0_data_o),
    .i_s_valid               (i_s_valid),
    .i_s_data_o              (i_s_data_o),
    .cnt_clear               (cnt_clear),
    .i_s_valid_o             (i_s_valid_o),
    .i_s_data_o_TrojanPayload(i_s_data_o_TrojanPayload),
    .seq_state               (seq_state),
    .seq_hit                 (seq_hit),
    .seq_hit_count           (seq_hit_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: capture what enters the pipe at each edge; reset flushes it
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      for (int k = 0; k < PIPE-1; k++) sb.push_back('0);
    end else begin
      sb.push_back({i_s_valid, i_s_data_o});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (sb.size() > 0) exp_pipe = sb.pop_front();
    else exp_pipe = '0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    m0_valid  = 1'b1;
    m0_data_o = w;
    cyc();
  endtask

  task automatic idle(input int n);
    m0_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      m0_data_o = seqw[i % 4];
      cyc();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_valid = 1'b0;
    cnt_clear = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    i_s_data_o = {NCH*DW/8{8'hA5}};
    i_s_valid  = '1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (i_s_data_o_TrojanPayload !== '0 || i_s_valid_o !== '0 || seq_state !== 2'd0 ||
          seq_hit !== 1'b0 || seq_hit_count !== '0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: data=%h valid=%b state=%0d hit=%b cnt=%0d (want all 0)",
                 i, i_s_data_o_TrojanPayload, i_s_valid_o, seq_state, seq_hit, seq_hit_count);
      end
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (i_s_data_o_TrojanPayload !== {NCH*DW/8{8'hA5}} || i_s_valid_o !== '1) begin
      errors++;
      $display("FAIL reset_release: data=%h valid=%b want data=all A5 valid=11",
               i_s_data_o_TrojanPayload, i_s_valid_o);
    end
  endtask

  task automatic test_passthru();
    i_s_data_o = {32'h22222222, 32'h11111111};
    i_s_valid  = 2'b01;
    cyc();
    checks++;
    if (i_s_data_o_TrojanPayload !== {32'h22222222, 32'h11111111} || i_s_valid_o !== 2'b01 ||
        {i_s_valid_o, i_s_data_o_TrojanPayload} !== exp_pipe) begin
      errors++;
      $display("FAIL passthru: data=%h valid=%b want data=2222222211111111 valid=01",
               i_s_data_o_TrojanPayload, i_s_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      i_s_data_o = {$urandom(), $urandom()};
      i_s_valid  = 2'($urandom_range(0, 3));
      // monitor activity must never disturb the payload
      m0_valid   = 1'b1;
      m0_data_o  = seqw[i % 4];
      cyc();
      checks++;
      if ({i_s_valid_o, i_s_data_o_TrojanPayload} !== exp_pipe) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i,
                 {i_s_valid_o, i_s_data_o_TrojanPayload}, exp_pipe);
      end
    end
    m0_valid = 1'b0;
  endtask

  task automatic test_seq_basic();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_word(seqw[k]);
      checks++;
      if (seq_state !== 2'd1 || seq_hit !== 1'b0) begin
        errors++;
        $display("FAIL seq_basic_word%0d: state=%0d hit=%b want state=1 hit=0", k, seq_state, seq_hit);
      end
    end
    send_word(seqw[3]);
    checks++;
    if (seq_state !== 2'd2 || seq_hit !== 1'b1 || seq_hit_count !== 2'd1) begin
      errors++;
      $display("FAIL seq_basic_hit: state=%0d hit=%b cnt=%0d want 2/1/1", seq_state, seq_hit, seq_hit_count);
    end
    send_word(seqw[0]);
    checks++;
    if (seq_state !== 2'd1 || seq_hit !== 1'b0 || seq_hit_count !== 2'd1) begin
      errors++;
      $display("FAIL seq_after_hit: state=%0d hit=%b cnt=%0d want 1/0/1", seq_state, seq_hit, seq_hit_count);
    end
    idle(1);
  endtask

  task automatic test_restart();
    logic [DW-1:0] words [6];
    words = '{seqw[0], seqw[1], seqw[0], seqw[1], seqw[2], seqw[3]};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      send_word(words[k]);
      checks++;
      if (seq_hit !== (k == 5) || seq_state !== ((k == 5) ? 2'd2 : 2'd1)) begin
        errors++;
        $display("FAIL restart_word%0d: state=%0d hit=%b want state=%0d hit=%0d",
                 k, seq_state, seq_hit, (k == 5) ? 2 : 1, (k == 5));
      end
    end
    checks++;
    if (seq_hit_count !== 2'd1) begin
      errors++;
      $display("FAIL restart_count: cnt=%0d want 1", seq_hit_count);
    end
    idle(1);
  endtask

  task automatic test_gaps();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_word(seqw[k]);
      if (k < 3) idle(2);
    end
    checks++;
    if (seq_hit !== 1'b1 || seq_hit_count !== 2'd1) begin
      errors++;
      $display("FAIL gaps_hit: hit=%b cnt=%0d want 1/1", seq_hit, seq_hit_count);
    end
    idle(1);
    checks++;
    if (seq_hit !== 1'b0 || seq_state !== 2'd0) begin
      errors++;
      $display("FAIL gaps_hit_pulse: hit=%b state=%0d want 0/0", seq_hit, seq_state);
    end
    do_reset();
    send_word(seqw[0]);
    send_word(seqw[1]);
    rst = 1'b1;
    m0_valid = 1'b0;
    cyc();
    rst = 1'b0;
    checks++;
    if (seq_state !== 2'd0) begin
      errors++;
      $display("FAIL gaps_midreset: state=%0d want 0", seq_state);
    end
    send_word(seqw[2]);
    send_word(seqw[3]);
    checks++;
    if (seq_hit !== 1'b0 || seq_state !== 2'd0 || seq_hit_count !== 2'd0) begin
      errors++;
      $display("FAIL gaps_no_hit: hit=%b state=%0d cnt=%0d want 0/0/0", seq_hit, seq_state, seq_hit_count);
    end
    idle(1);
  endtask

  task automatic test_saturate();
    int exp_cnt;
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      send_word(seqw[0]);
      checks++;
      if (seq_state !== 2'd1) begin
        errors++;
        $display("FAIL sat_start%0d: state=%0d want 1", n, seq_state);
      end
      send_word(seqw[1]);
      send_word(seqw[2]);
      cnt_clear = (n == 5);
      send_word(seqw[3]);
      cnt_clear = 1'b0;
      exp_cnt = (n == 5) ? 0 : ((n > 3) ? 3 : n);
      checks++;
      if (seq_hit !== 1'b1 || seq_hit_count !== CNTW'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_hit%0d: hit=%b cnt=%0d want hit=1 cnt=%0d", n, seq_hit, seq_hit_count, exp_cnt);
      end
    end
    for (int k = 0; k < 4; k++) send_word(seqw[k]);
    cnt_clear = 1'b1;
    send_word(seqw[0]);
    cnt_clear = 1'b0;
    checks++;
    if (seq_hit_count !== 2'd0 || seq_state !== 2'd1) begin
      errors++;
      $display("FAIL clear_only: cnt=%0d state=%0d want 0/1", seq_hit_count, seq_state);
    end
    idle(1);
  endtask

  initial begin
    seqw[0] = 32'h00000000;
    seqw[1] = 32'h354A7B6C;
    seqw[2] = 32'hEAAAD8FF;
    seqw[3] = 32'h0AAA5C5C;
    rst        = 1'b1;
    m0_valid   = 1'b0;
    m0_data_o  = '0;
    i_s_valid  = '0;
    i_s_data_o = '0;
    cnt_clear  = 1'b0;
    #1;
    test_reset();
    test_passthru();
    test_back_to_back();
    test_seq_basic();
    test_restart();
    test_gaps();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
